tcb_lite_arbiter: RTL and testbench

Round-robin arbiter that shares one TCB-Lite subordinate between IFN TCB-Lite managers. It sits between several bus managers (CPU instruction/data ports, DMA) and a single memory or peripheral subordinate. It forwards the granted manager's request with zero added latency and supports arbitration lock (`req.lck`). It also routes each response back to its originating manager after the fixed response delay DLY.

---
 rtl/tcb_lite_if.sv | 40 ++++
 rtl/tcb_lite_arbiter.sv | 75 +++++++
 tb/tb_tcb_lite_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tcb_lite_if.sv
// tcb_lite_if: TCB-Lite handshake bundle with a transfer delay line for response qualification
interface tcb_lite_if #(
  parameter int DLY = 1,
  parameter int DAT = 32,
  parameter int ADR = DAT
) (
  input logic clk,
  input logic rst
);
  logic             vld;
  logic             rdy;
  logic             trn;
  logic             stl;
  logic             req_lck;
  logic             req_wen;
  logic [ADR-1:0]   req_adr;
  logic [DAT/8-1:0] req_ben;
  logic [DAT-1:0]   req_wdt;
  logic [DAT-1:0]   rsp_rdt;
  logic             rsp_err;
  logic [DLY:0]     trn_dly;
  assign trn = vld & rdy;
  assign stl = vld & ~rdy;
  if (DLY == 0) begin : g_d0
    assign trn_dly = trn;
  end else begin : g_dn
    logic [DLY-1:0] trn_q;
    always_ff @(posedge clk)
      trn_q <= rst ? '0 : DLY'({trn_q, trn});
    assign trn_dly = {trn_q, trn};
  end
  modport man (
    output vld, req_lck, req_wen, req_adr, req_ben, req_wdt,
    input  rdy, rsp_rdt, rsp_err, trn, stl, trn_dly
  );
  modport sub (
    input  vld, req_lck, req_wen, req_adr, req_ben, req_wdt, trn, stl, trn_dly,
    output rdy, rsp_rdt, rsp_err
  );
endinterface

// File: rtl/tcb_lite_arbiter.sv
// tcb_lite_arbiter: round-robin TCB-Lite arbiter with lock and delayed response routing
module tcb_lite_arbiter #(
  parameter int IFN = 2,
  parameter int DLY = 1,
  parameter int DAT = 32,
  parameter int ADR = DAT
) (
  input logic     clk,
  input logic     rst,
  tcb_lite_if.sub man [IFN-1:0],
  tcb_lite_if.man sub
);
  localparam int IDW = (IFN > 1) ? $clog2(IFN) : 1;
  logic [IFN-1:0]   vld;
  logic [IFN-1:0]   lck;
  logic [IFN-1:0]   wen;
  logic [ADR-1:0]   adr [IFN];
  logic [DAT/8-1:0] ben [IFN];
  logic [DAT-1:0]   wdt [IFN];
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   lck_own;
  logic             lck_act;
  logic [IDW-1:0]   arb;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   rsp_sel;
  for (genvar i = 0; i < IFN; i++) begin : g_m
    assign vld[i] = man[i].vld;
    assign lck[i] = man[i].req_lck;
    assign wen[i] = man[i].req_wen;
    assign adr[i] = man[i].req_adr;
    assign ben[i] = man[i].req_ben;
    assign wdt[i] = man[i].req_wdt;
    assign man[i].rdy     = sub.rdy & (sel == IDW'(i));
    assign man[i].rsp_rdt = (rsp_sel == IDW'(i)) ? sub.rsp_rdt : 'x;
    assign man[i].rsp_err = (rsp_sel == IDW'(i)) ? sub.rsp_err : 1'bx;
  end
  // scan from the highest offset down so the first valid index after ptr wins
  always_comb begin
    arb = ptr;
    idx = '0;
    for (int k = IFN - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % IFN);
      arb = vld[idx] ? idx : arb;
    end
  end
  assign sel         = lck_act ? lck_own : arb;
  assign sub.vld     = vld[sel];
  assign sub.req_lck = lck[sel];
  assign sub.req_wen = wen[sel];
  assign sub.req_adr = adr[sel];
  assign sub.req_ben = ben[sel];
  assign sub.req_wdt = wdt[sel];
  always_ff @(posedge clk)
    if (rst) begin
      ptr     <= '0;
      lck_act <= 1'b0;
      lck_own <= '0;
    end else if (sub.trn) begin
      ptr     <= (int'(sel) == IFN - 1) ? '0 : sel + 1'b1;
      lck_act <= lck[sel];
      lck_own <= lck[sel] ? sel : lck_own;
    end
  if (DLY == 0) begin : g_r0
    assign rsp_sel = sel;
  end else begin : g_rn
    logic [IDW-1:0] sel_dly [1:DLY];
    always_ff @(posedge clk)
      if (rst) sel_dly <= '{default: '0};
      else
        for (int k = 1; k <= DLY; k++)
          if (sub.trn_dly[k-1]) sel_dly[k] <= (k == 1) ? sel : sel_dly[(k > 1) ? k - 1 : 1];
    assign rsp_sel = sel_dly[DLY];
  end
endmodule

// File: tb/tb_tcb_lite_arbiter.sv
// tb_tcb_lite_arbiter: randomized managers and subordinate with a queue scoreboard for grants and responses
module tb_tcb_lite_arbiter;
  localparam int IFN = 3, DLY = 2, DAT = 32, ADR = 32;
  typedef struct packed { int g; logic lck; logic wen; logic [3:0] ben; logic [31:0] adr; logic [31:0] wdt; } req_e;
  typedef struct packed { int g; logic [31:0] rdt; int due; } rsp_e;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tcb_lite_if #(.DLY(DLY), .DAT(DAT), .ADR(ADR)) man [IFN-1:0] (.clk(clk), .rst(rst));
  tcb_lite_if #(.DLY(DLY), .DAT(DAT), .ADR(ADR)) sub (.clk(clk), .rst(rst));
  tcb_lite_arbiter #(.IFN(IFN), .DLY(DLY), .DAT(DAT), .ADR(ADR)) dut (.clk(clk), .rst(rst), .man(man), .sub(sub));
  logic [IFN-1:0] m_vld, m_lck, m_wen, d_rdy, d_td, d_err, tx, exp_rdy;
  logic [3:0]     m_ben [IFN];
  logic [31:0]    m_adr [IFN];
  logic [31:0]    m_wdt [IFN];
  logic [31:0]    d_rdt [IFN];
  logic           s_rdy, s_err, exp_svld, last_trn;
  logic [31:0]    s_rdt, last_adr;
  logic [31:0]    rp [1:DLY];
  req_e           req_q [$];
  rsp_e           rsp_q [$];
  int             vec = 0, errs = 0, cyc = 0;
  int             mptr = 0, mown = 0;
  bit             mlck = 0;
  for (genvar i = 0; i < IFN; i++) begin : g_b
    assign man[i].vld     = m_vld[i];
    assign man[i].req_lck = m_lck[i];
    assign man[i].req_wen = m_wen[i];
    assign man[i].req_adr = m_adr[i];
    assign man[i].req_ben = m_ben[i];
    assign man[i].req_wdt = m_wdt[i];
    assign d_rdy[i] = man[i].rdy;
    assign d_td[i]  = man[i].trn_dly[DLY];
    assign d_rdt[i] = man[i].rsp_rdt;
    assign d_err[i] = man[i].rsp_err;
  end
  assign sub.rdy     = s_rdy;
  assign sub.rsp_rdt = s_rdt;
  assign sub.rsp_err = s_err;
  function automatic logic [31:0] rdt_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // grant rule: lock owner, else first valid manager at or after the pointer, else the pointer
  task automatic predict();
    int g;
    bit found;
    g = mlck ? mown : mptr;
    found = mlck;
    for (int k = 0; k < IFN; k++)
      if (!found && m_vld[(mptr + k) % IFN]) begin
        g = (mptr + k) % IFN;
        found = 1;
      end
    exp_rdy = '0;
    if (s_rdy) exp_rdy[g] = 1'b1;
    exp_svld = m_vld[g];
    if (m_vld[g] && s_rdy) begin
      req_q.push_back('{g, m_lck[g], m_wen[g], m_ben[g], m_adr[g], m_wdt[g]});
      rsp_q.push_back('{g, rdt_of(m_adr[g]), cyc + DLY});
      mptr = (g + 1) % IFN;
      mlck = m_lck[g];
      if (m_lck[g]) mown = g;
    end
  endtask
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    for (int k = DLY; k >= 2; k--) rp[k] = rp[k-1];
    rp[1] = last_trn ? rdt_of(last_adr) : '0;
    s_rdt = rp[DLY];
    s_err = rp[DLY][0];
    for (int i = 0; i < IFN; i++)
      if (!m_vld[i] || tx[i]) begin
        m_vld[i] = (mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
        m_lck[i] = (mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
        m_wen[i] = 1'($urandom_range(0, 1));
        m_ben[i] = 4'($urandom);
        m_adr[i] = $urandom;
        m_wdt[i] = $urandom;
      end
    s_rdy = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    predict();
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_vld = '0;
    s_rdy = 1'b0;
    tx = '0;
    last_trn = 1'b0;
    for (int k = 1; k <= DLY; k++) rp[k] = '0;
    s_rdt = '0;
    s_err = 1'b0;
    req_q.delete();
    rsp_q.delete();
    mptr = 0;
    mlck = 0;
    mown = 0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      req_e e;
      rsp_e r;
      logic [IFN-1:0] exp_td;
      check("man_rdy", 64'(d_rdy), 64'(exp_rdy));
      check("sub_vld", 64'(sub.vld), 64'(exp_svld));
      if (sub.trn) begin
        if (req_q.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL unexpected_trn at cycle %0d: got transfer expected none", cyc);
        end else begin
          e = req_q.pop_front();
          check("sub_adr", 64'(sub.req_adr), 64'(e.adr));
          check("sub_wdt", 64'(sub.req_wdt), 64'(e.wdt));
          check("sub_ben", 64'(sub.req_ben), 64'(e.ben));
          check("sub_wen", 64'(sub.req_wen), 64'(e.wen));
          check("sub_lck", 64'(sub.req_lck), 64'(e.lck));
        end
      end
      if (req_q.size() != 0) begin
        vec++;
        errs++;
        $display("FAIL missing_trn at cycle %0d: got no transfer expected one", cyc);
        req_q.delete();
      end
      exp_td = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) exp_td[rsp_q[0].g] = 1'b1;
      check("rsp_route", 64'(d_td), 64'(exp_td));
      if (exp_td != '0) begin
        r = rsp_q.pop_front();
        check("rsp_rdt", 64'(d_rdt[r.g]), 64'(r.rdt));
        check("rsp_err", 64'(d_err[r.g]), 64'(r.rdt[0]));
      end
      last_trn = sub.trn;
      last_adr = sub.req_adr;
      tx = d_rdy & m_vld;
    end
  initial begin
    m_vld = '0; m_lck = '0; m_wen = '0; tx = '0;
    for (int i = 0; i < IFN; i++) begin
      m_ben[i] = '0; m_adr[i] = '0; m_wdt[i] = '0;
    end
    s_rdy = 1'b0; s_rdt = '0; s_err = 1'b0; last_trn = 1'b0; last_adr = '0;
    exp_rdy = '0; exp_svld = 1'b0;
    for (int k = 1; k <= DLY; k++) rp[k] = '0;
    repeat (3) @(posedge clk);
    for (int n = 0; n < 6; n++) step(1);
    for (int n = 0; n < 1500; n++) step(0);
    for (int n = 0; n < 500 && !mlck; n++) step(0);
    do_reset();
    for (int n = 0; n < 4; n++) step(1);
    for (int n = 0; n < 1000; n++) step(0);
    for (int n = 0; n < DLY + 2; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = DLY; k >= 2; k--) rp[k] = rp[k-1];
      rp[1] = last_trn ? rdt_of(last_adr) : '0;
      s_rdt = rp[DLY];
      s_err = rp[DLY][0];
      m_vld = '0;
      s_rdy = 1'b0;
      predict();
    end
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
